conv_1g_port_mux_arb: RTL and testbench
=======================================

Name: conv_1G_port_mux_arb

Overview:
Packet-granular round-robin arbiter that merges PORTS per-port 1G RX packet streams into one shared 64-bit packet FIFO towards the system bus. Each input is a show-ahead FIFO head carrying data, status (SOP/EOP/mod) and error bits. Once a port is granted at SOP, the grant is held until EOP, a forced abort, or a watchdog timeout. The block also drops stray fragments, tags each word with its source port, and reports packet length at EOP.

Parameters:
PORTS, 4, number of input ports (2..16)
WDT_CYCLES, 600, max cycles in PASS_S without a pop before a forced abort
ID_W, $clog2(PORTS) (min 1), port-id width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
in_avail_i  in  PORTS  head word valid, per port
in_data_i  in  64*PORTS  head data; port k = [64k+63:64k]
in_sop_i  in  PORTS  head word is SOP
in_eop_i  in  PORTS  head word is EOP
in_mod_i  in  3*PORTS  valid bytes in EOP word; 0 = 8 bytes
in_crc_err_i  in  PORTS  CRC error, qualified with EOP
in_rd_o  out  PORTS  pop strobe, one-hot or zero
out_full_i  in  1  output FIFO almost-full (one-word margin)
out_val_o  out  1  output word valid
out_data_o  out  64  data
out_status_o  out  8  [7]=SOP, [6]=EOP, [2:0]=mod
out_error_o  out  3  [0]=CRC or forced error; [2:1]=0
out_port_o  out  ID_W  source port of the word
out_len_o  out  16  packet byte length; valid only with EOP, else 0
drop_cnt_o  out  16  dropped fragment words, saturating
abort_cnt_o  out  16  forced aborts, saturating

Behaviour:
- Clock and reset: single clock domain. rst_n_i low asynchronously clears every output and counter to 0, sets state to IDLE_S and sets the RR pointer to PORTS-1 (port 0 is considered first).
- Output timing: all out_* are registered. A word popped in cycle t appears on out_* at t+1. in_rd_o is combinational from state and heads.
- FSM states: IDLE_S, PASS_S, ABORT_S.
- IDLE_S, with out_full_i=1: no action.
- IDLE_S, with out_full_i=0: scan ptr+1 .. ptr+PORTS (mod PORTS) and select the first port k with in_avail_i[k]=1.
  - If head SOP=1 and EOP=0: pop, forward the word with status[7]=1, grant=k, go to PASS_S.
  - Otherwise (no SOP, or SOP+EOP fragment): pop and discard, drop_cnt++, ptr=k, stay in IDLE_S.
- PASS_S, granted port g, with in_avail_i[g]=1 and out_full_i=0:
  - Head SOP=1: no pop, go to ABORT_S. The new SOP is kept for a later grant.
  - Head EOP=1: pop, forward with status[6]=1, mod, error[0]=crc_err; ptr=g; go to IDLE_S.
  - Otherwise: pop, forward, stay in PASS_S.
- PASS_S, other inputs: out_full_i=1 stalls with no pop and the watchdog held. Other ports are never popped while a grant is held.
- Watchdog: counter cleared on each pop and on leaving PASS_S. It increments while in PASS_S with in_avail_i[g]=0 and out_full_i=0. Reaching WDT_CYCLES sends the FSM to ABORT_S.
- ABORT_S: wait for out_full_i=0, then emit one dummy word on the next cycle: data=0, status=8'h40 (EOP, mod 0), error[0]=1, out_port_o=g. Then abort_cnt++, ptr=g, go to IDLE_S. ABORT_S performs no pop.
- Length: the per-packet byte counter is 16 bit.
  - It is loaded with 8 when the SOP word is forwarded and adds 8 per forwarded non-EOP word.
  - At a real EOP, out_len_o = acc + (mod==0 ? 8 : mod).
  - At a forced EOP, out_len_o = acc + 8 (the dummy word counts).
  - The counter wraps modulo 2^16.
- Priority: the SOP check outranks the EOP check in PASS_S. Saturating counters hold at 16'hFFFF.
- Output word count: exactly one out_val_o per pop, plus one per abort. in_rd_o never asserts for a port whose in_avail_i=0.

Test Plan:
1. Fairness: ports 0 and 2 each hold a 3-word packet (SOP, mid, EOP mod=4) from reset. Required: port 0 is served first, then port 2; out_port_o sequence 0,0,0,2,2,2; both EOP words have out_len_o=20 (3-word packet = 8+8+4); no gaps once started.
2. Fragment drop: port 1 head is a non-SOP word, followed by SOP+EOP. Required: 2 pops, out_val_o never asserts, drop_cnt_o=2, FSM stays in IDLE_S.
3. Missing EOP: port 3 sends SOP, mid, then a new SOP. Required: 2 words forwarded, then a dummy EOP word (status 8'h40, error 3'b001, len 24); abort_cnt_o=1; the new SOP is popped on a later grant.
4. Watchdog: port 0 sends SOP only, then in_avail_i[0]=0. Required: forced EOP word appears exactly WDT_CYCLES+1 cycles after leaving the wait, i.e. ABORT_S is entered at count 600, with len 16.
5. Backpressure: assert out_full_i for 50 cycles mid-packet. Required: in_rd_o=0 throughout, no watchdog abort, stream resumes with no loss or duplication.
6. Reset mid-packet: drop rst_n_i during PASS_S. Required: all outputs are 0 immediately (asynchronously); after release, arbitration restarts at port 0.

Source files
------------

// File: rtl/conv_1g_port_mux_arb.sv
// Packet-granular round-robin merge of PORTS 1G RX head FIFOs into one
// 64-bit output stream. A grant taken at SOP is held until EOP, until a new
// SOP shows up on the granted port, or until the watchdog expires; the last
// two cases close the packet with a dummy errored EOP word.
module conv_1g_port_mux_arb #(
  parameter int PORTS      = 4,
  parameter int WDT_CYCLES = 600,
  parameter int ID_W       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [PORTS-1:0]    in_avail_i,
  input  logic [64*PORTS-1:0] in_data_i,
  input  logic [PORTS-1:0]    in_sop_i,
  input  logic [PORTS-1:0]    in_eop_i,
  input  logic [3*PORTS-1:0]  in_mod_i,
  input  logic [PORTS-1:0]    in_crc_err_i,
  output logic [PORTS-1:0]    in_rd_o,
  input  logic                out_full_i,
  output logic                out_val_o,
  output logic [63:0]         out_data_o,
  output logic [7:0]          out_status_o,
  output logic [2:0]          out_error_o,
  output logic [ID_W-1:0]     out_port_o,
  output logic [15:0]         out_len_o,
  output logic [15:0]         drop_cnt_o,
  output logic [15:0]         abort_cnt_o
);

  typedef enum logic [1:0] {IDLE_S, PASS_S, ABORT_S} state_t;

  localparam int              WDT_W   = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LIM = WDT_W'(WDT_CYCLES);
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(PORTS - 1);

  // Saturating event counter increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Byte count carried by an EOP word; mod 0 means a full word.
  function automatic logic [15:0] eop_bytes(input logic [2:0] m);
    return (m == 3'd0) ? 16'd8 : {13'd0, m};
  endfunction

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [WDT_W-1:0]  wdt_q, wdt_d, wdt_inc;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       drop_q, drop_d;
  logic [15:0]       abort_q, abort_d;

  logic [63:0]       data_arr [PORTS];
  logic [2:0]        mod_arr  [PORTS];

  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic [ID_W-1:0]   cand;

  logic [PORTS-1:0]  rd_p0;
  logic              vld_p0, vld_p1;
  logic [63:0]       data_p0, data_p1;
  logic [7:0]        status_p0, status_p1;
  logic [2:0]        error_p0, error_p1;
  logic [ID_W-1:0]   port_p0, port_p1;
  logic [15:0]       len_p0, len_p1;

  for (genvar p = 0; p < PORTS; p++) begin : g_unpack
    assign data_arr[p] = in_data_i[64*p +: 64];
    assign mod_arr[p]  = in_mod_i[3*p +: 3];
  end

  assign wdt_inc = wdt_q + 1'b1;

  // Round-robin scan: first available port after the pointer.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= PORTS; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % PORTS);
      if (!sel_found && in_avail_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Stage p0: next-state, pop strobe and the word to be registered.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    wdt_d     = wdt_q;
    acc_d     = acc_q;
    drop_d    = drop_q;
    abort_d   = abort_q;
    rd_p0     = '0;
    vld_p0    = 1'b0;
    data_p0   = '0;
    status_p0 = '0;
    error_p0  = '0;
    port_p0   = '0;
    len_p0    = '0;
    unique case (state_q)
      IDLE_S: begin
        if (!out_full_i && sel_found) begin
          rd_p0[sel_idx] = 1'b1;
          if (in_sop_i[sel_idx] && !in_eop_i[sel_idx]) begin
            vld_p0    = 1'b1;
            data_p0   = data_arr[sel_idx];
            status_p0 = 8'h80;
            port_p0   = sel_idx;
            grant_d   = sel_idx;
            acc_d     = 16'd8;
            wdt_d     = '0;
            state_d   = PASS_S;
          end else begin
            // Stray mid/EOP word or single-word SOP+EOP: discard it.
            drop_d = sat_inc(drop_q);
            ptr_d  = sel_idx;
          end
        end
      end
      PASS_S: begin
        if (!out_full_i) begin
          if (in_avail_i[grant_q]) begin
            wdt_d = '0;
            if (in_sop_i[grant_q]) begin
              // Packet lost its EOP; keep the new SOP for a later grant.
              state_d = ABORT_S;
            end else begin
              rd_p0[grant_q] = 1'b1;
              vld_p0         = 1'b1;
              data_p0        = data_arr[grant_q];
              port_p0        = grant_q;
              if (in_eop_i[grant_q]) begin
                status_p0 = {2'b01, 3'b000, mod_arr[grant_q]};
                error_p0  = {2'b00, in_crc_err_i[grant_q]};
                len_p0    = acc_q + eop_bytes(mod_arr[grant_q]);
                ptr_d     = grant_q;
                state_d   = IDLE_S;
              end else begin
                acc_d = acc_q + 16'd8;
              end
            end
          end else begin
            wdt_d = wdt_inc;
            if (wdt_inc == WDT_LIM) begin
              wdt_d   = '0;
              state_d = ABORT_S;
            end
          end
        end
      end
      ABORT_S: begin
        if (!out_full_i) begin
          vld_p0    = 1'b1;
          status_p0 = 8'h40;
          error_p0  = 3'b001;
          port_p0   = grant_q;
          len_p0    = acc_q + 16'd8;
          abort_d   = sat_inc(abort_q);
          ptr_d     = grant_q;
          state_d   = IDLE_S;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // Control state: FSM, grant, RR pointer, watchdog, length and counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE_S;
      grant_q <= '0;
      ptr_q   <= PTR_RST;
      wdt_q   <= '0;
      acc_q   <= '0;
      drop_q  <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      wdt_q   <= wdt_d;
      acc_q   <= acc_d;
      drop_q  <= drop_d;
      abort_q <= abort_d;
    end
  end

  // Stage p1: registered output word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      status_p1 <= '0;
      error_p1  <= '0;
      port_p1   <= '0;
      len_p1    <= '0;
    end else begin
      vld_p1    <= vld_p0;
      data_p1   <= data_p0;
      status_p1 <= status_p0;
      error_p1  <= error_p0;
      port_p1   <= port_p0;
      len_p1    <= len_p0;
    end
  end

  assign in_rd_o      = rd_p0 & {PORTS{rst_n_i}};
  assign out_val_o    = vld_p1;
  assign out_data_o   = data_p1;
  assign out_status_o = status_p1;
  assign out_error_o  = error_p1;
  assign out_port_o   = port_p1;
  assign out_len_o    = len_p1;
  assign drop_cnt_o   = drop_q;
  assign abort_cnt_o  = abort_q;

endmodule

// File: tb/tb_conv_1g_port_mux_arb.sv
// Scoreboard bench for conv_1g_port_mux_arb: per-port head queues feed the
// DUT, expected output words are queued by the stimulus and popped by a
// monitor whenever out_val_o is seen.
module tb_conv_1g_port_mux_arb;

  localparam int PORTS = 4;
  localparam int WDT   = 600;
  localparam int ID_W  = 2;

  logic                clk_i = 1'b0;
  logic                rst_n_i;
  logic [PORTS-1:0]    in_avail_i;
  logic [64*PORTS-1:0] in_data_i;
  logic [PORTS-1:0]    in_sop_i;
  logic [PORTS-1:0]    in_eop_i;
  logic [3*PORTS-1:0]  in_mod_i;
  logic [PORTS-1:0]    in_crc_err_i;
  logic [PORTS-1:0]    in_rd_o;
  logic                out_full_i;
  logic                out_val_o;
  logic [63:0]         out_data_o;
  logic [7:0]          out_status_o;
  logic [2:0]          out_error_o;
  logic [ID_W-1:0]     out_port_o;
  logic [15:0]         out_len_o;
  logic [15:0]         drop_cnt_o;
  logic [15:0]         abort_cnt_o;

  conv_1g_port_mux_arb #(.PORTS(PORTS), .WDT_CYCLES(WDT), .ID_W(ID_W)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .in_avail_i   (in_avail_i),
    .in_data_i    (in_data_i),
    .in_sop_i     (in_sop_i),
    .in_eop_i     (in_eop_i),
    .in_mod_i     (in_mod_i),
    .in_crc_err_i (in_crc_err_i),
    .in_rd_o      (in_rd_o),
    .out_full_i   (out_full_i),
    .out_val_o    (out_val_o),
    .out_data_o   (out_data_o),
    .out_status_o (out_status_o),
    .out_error_o  (out_error_o),
    .out_port_o   (out_port_o),
    .out_len_o    (out_len_o),
    .drop_cnt_o   (drop_cnt_o),
    .abort_cnt_o  (abort_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        crc;
  } in_t;

  typedef struct packed {
    logic [63:0]     d;
    logic [7:0]      st;
    logic [2:0]      err;
    logic [ID_W-1:0] port;
    logic [15:0]     len;
  } out_t;

  in_t              inq [PORTS][$];
  out_t             expq [$];
  int               n_chk;
  int               n_fail;
  int               vld_count;
  int               cyc;
  logic [PORTS-1:0] rd_snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_in(input int p, input logic [63:0] d, input logic sop,
                         input logic eop, input logic [2:0] mod, input logic crc);
    inq[p].push_back('{d: d, sop: sop, eop: eop, mod: mod, crc: crc});
  endtask

  task automatic push_exp(input logic [63:0] d, input logic [7:0] st, input logic [2:0] err,
                          input int p, input logic [15:0] len);
    expq.push_back('{d: d, st: st, err: err, port: ID_W'(p), len: len});
  endtask

  task automatic refresh_heads();
    for (int p = 0; p < PORTS; p++) begin
      if (inq[p].size() > 0) begin
        in_avail_i[p]        = 1'b1;
        in_data_i[64*p +: 64] = inq[p][0].d;
        in_sop_i[p]          = inq[p][0].sop;
        in_eop_i[p]          = inq[p][0].eop;
        in_mod_i[3*p +: 3]   = inq[p][0].mod;
        in_crc_err_i[p]      = inq[p][0].crc;
      end else begin
        in_avail_i[p]        = 1'b0;
        in_data_i[64*p +: 64] = '0;
        in_sop_i[p]          = 1'b0;
        in_eop_i[p]          = 1'b0;
        in_mod_i[3*p +: 3]   = '0;
        in_crc_err_i[p]      = 1'b0;
      end
    end
  endtask

  task automatic wait_vld(input int target, input string name, output int t);
    int b;
    b = 0;
    while (vld_count < target && b < 2000) begin
      @(negedge clk_i);
      #1;
      b++;
    end
    t = cyc;
    if (vld_count < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: timeout, words seen %0d required %0d", name, vld_count, target);
    end
  endtask

  task automatic wait_drain(input string name);
    int b;
    b = 0;
    while (expq.size() != 0 && b < 2000) begin
      @(negedge clk_i);
      #1;
      b++;
    end
    check(name, 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int t0, t1, base;
    rst_n_i      = 1'b0;
    out_full_i   = 1'b0;
    in_avail_i   = '0;
    in_data_i    = '0;
    in_sop_i     = '0;
    in_eop_i     = '0;
    in_mod_i     = '0;
    in_crc_err_i = '0;
    n_chk        = 0;
    n_fail       = 0;
    vld_count    = 0;
    cyc          = 0;
    rd_snap      = '0;

    fork
      // Feeder: apply the pops the DUT requested, then present new heads.
      forever begin
        @(posedge clk_i);
        cyc++;
        #1;
        for (int p = 0; p < PORTS; p++)
          if (rd_snap[p] && inq[p].size() > 0) void'(inq[p].pop_front());
        rd_snap = '0;
        refresh_heads();
      end
      // Monitor: pop-strobe legality and scoreboard comparison of every word.
      forever begin
        out_t got, req;
        @(negedge clk_i);
        if (rst_n_i) begin
          rd_snap = in_rd_o;
          if (in_rd_o != '0) begin
            n_chk++;
            if (!$onehot(in_rd_o) || ((in_rd_o & ~in_avail_i) != '0)) begin
              n_fail++;
              $display("FAIL rd_legal: in_rd %b in_avail %b", in_rd_o, in_avail_i);
            end
          end
          if (out_val_o) begin
            vld_count++;
            got = '{d: out_data_o, st: out_status_o, err: out_error_o,
                    port: out_port_o, len: out_len_o};
            n_chk++;
            if (expq.size() == 0) begin
              n_fail++;
              $display("FAIL word_unexpected: actual d=%h st=%h err=%b port=%0d len=%0d required none",
                       got.d, got.st, got.err, got.port, got.len);
            end else begin
              req = expq.pop_front();
              if (got !== req) begin
                n_fail++;
                $display("FAIL word%0d: actual d=%h st=%h err=%b port=%0d len=%0d required d=%h st=%h err=%b port=%0d len=%0d",
                         vld_count, got.d, got.st, got.err, got.port, got.len,
                         req.d, req.st, req.err, req.port, req.len);
              end
            end
          end
        end else begin
          rd_snap = '0;
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_out_val", 64'(out_val_o), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    check("rst_abort_cnt", 64'(abort_cnt_o), 64'd0);
    check("rst_out_len", 64'(out_len_o), 64'd0);
    @(posedge clk_i);
    #2 rst_n_i = 1'b1;

    // 1. Fairness: ports 0 and 2 both ready, port 0 first, back-to-back.
    push_in(0, 64'hA0, 1, 0, 3'd0, 0);
    push_in(0, 64'hA1, 0, 0, 3'd0, 0);
    push_in(0, 64'hA2, 0, 1, 3'd4, 0);
    push_in(2, 64'hB0, 1, 0, 3'd0, 0);
    push_in(2, 64'hB1, 0, 0, 3'd0, 0);
    push_in(2, 64'hB2, 0, 1, 3'd4, 1);
    push_exp(64'hA0, 8'h80, 3'b000, 0, 16'd0);
    push_exp(64'hA1, 8'h00, 3'b000, 0, 16'd0);
    push_exp(64'hA2, 8'h44, 3'b000, 0, 16'd20);
    push_exp(64'hB0, 8'h80, 3'b000, 2, 16'd0);
    push_exp(64'hB1, 8'h00, 3'b000, 2, 16'd0);
    push_exp(64'hB2, 8'h44, 3'b001, 2, 16'd20);
    base = vld_count;
    wait_vld(base + 1, "fair_first", t0);
    wait_vld(base + 6, "fair_last", t1);
    check("fair_no_gap", 64'(t1 - t0), 64'd5);
    wait_drain("fair_drain");

    // 2. Fragment drop on port 1: non-SOP word then SOP+EOP.
    base = vld_count;
    push_in(1, 64'hC5, 0, 0, 3'd0, 0);
    push_in(1, 64'hC6, 1, 1, 3'd2, 0);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    check("frag_drop_cnt", 64'(drop_cnt_o), 64'd2);
    check("frag_popped", 64'(inq[1].size()), 64'd0);
    check("frag_no_output", 64'(vld_count - base), 64'd0);

    // 3. Missing EOP on port 3: forced EOP, then the new SOP is served.
    push_in(3, 64'hD0, 1, 0, 3'd0, 0);
    push_in(3, 64'hD1, 0, 0, 3'd0, 0);
    push_in(3, 64'hE0, 1, 0, 3'd0, 0);
    push_in(3, 64'hE1, 0, 1, 3'd0, 0);
    push_exp(64'hD0, 8'h80, 3'b000, 3, 16'd0);
    push_exp(64'hD1, 8'h00, 3'b000, 3, 16'd0);
    push_exp(64'h0,  8'h40, 3'b001, 3, 16'd24);
    push_exp(64'hE0, 8'h80, 3'b000, 3, 16'd0);
    push_exp(64'hE1, 8'h40, 3'b000, 3, 16'd16);
    wait_drain("noeop_drain");
    check("noeop_abort_cnt", 64'(abort_cnt_o), 64'd1);
    check("noeop_drop_cnt", 64'(drop_cnt_o), 64'd2);

    // 4. Watchdog: port 0 sends SOP only.
    push_in(0, 64'hF0, 1, 0, 3'd0, 0);
    push_exp(64'hF0, 8'h80, 3'b000, 0, 16'd0);
    push_exp(64'h0,  8'h40, 3'b001, 0, 16'd16);
    base = vld_count;
    wait_vld(base + 1, "wdt_sop", t0);
    wait_vld(base + 2, "wdt_abort", t1);
    check("wdt_delay", 64'(t1 - t0), 64'(WDT + 1));
    check("wdt_abort_cnt", 64'(abort_cnt_o), 64'd2);

    // 5. Backpressure for 50 cycles mid-packet on port 2.
    push_in(2, 64'h50, 1, 0, 3'd0, 0);
    push_in(2, 64'h51, 0, 0, 3'd0, 0);
    push_in(2, 64'h52, 0, 0, 3'd0, 0);
    push_in(2, 64'h53, 0, 1, 3'd0, 0);
    push_exp(64'h50, 8'h80, 3'b000, 2, 16'd0);
    push_exp(64'h51, 8'h00, 3'b000, 2, 16'd0);
    push_exp(64'h52, 8'h00, 3'b000, 2, 16'd0);
    push_exp(64'h53, 8'h40, 3'b000, 2, 16'd32);
    base = vld_count;
    wait_vld(base + 2, "bp_start", t0);
    @(posedge clk_i);
    #1 out_full_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      check("bp_no_rd", 64'(in_rd_o), 64'd0);
    end
    @(posedge clk_i);
    #1 out_full_i = 1'b0;
    wait_drain("bp_drain");
    check("bp_abort_cnt", 64'(abort_cnt_o), 64'd2);

    // 6. Reset mid-packet on port 1, then restart at port 0.
    push_in(1, 64'h60, 1, 0, 3'd0, 0);
    push_in(1, 64'h61, 0, 0, 3'd0, 0);
    push_exp(64'h60, 8'h80, 3'b000, 1, 16'd0);
    base = vld_count;
    wait_vld(base + 1, "rstmid_sop", t0);
    @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    check("rstmid_val", 64'(out_val_o), 64'd0);
    check("rstmid_data", out_data_o, 64'd0);
    check("rstmid_fields", 64'({out_status_o, out_error_o, out_port_o, out_len_o}), 64'd0);
    check("rstmid_rd", 64'(in_rd_o), 64'd0);
    check("rstmid_cnts", 64'({drop_cnt_o, abort_cnt_o}), 64'd0);
    for (int p = 0; p < PORTS; p++) inq[p].delete();
    check("rstmid_exp_empty", 64'(expq.size()), 64'd0);
    repeat (3) @(posedge clk_i);
    #2 rst_n_i = 1'b1;
    push_in(1, 64'h71, 1, 0, 3'd0, 0);
    push_in(1, 64'h72, 0, 1, 3'd2, 0);
    push_in(0, 64'h81, 1, 0, 3'd0, 0);
    push_in(0, 64'h82, 0, 1, 3'd0, 0);
    push_exp(64'h81, 8'h80, 3'b000, 0, 16'd0);
    push_exp(64'h82, 8'h40, 3'b000, 0, 16'd16);
    push_exp(64'h71, 8'h80, 3'b000, 1, 16'd0);
    push_exp(64'h72, 8'h42, 3'b000, 1, 16'd10);
    wait_drain("rstmid_restart");
    check("rstmid_abort_after", 64'(abort_cnt_o), 64'd0);

    repeat (5) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
